lowampa_trig_qualifier: RTL

//  Per-beam, per-level trigger qualifier between the LF beamformer trigger outputs and the scalers/L1 output.

---
 rtl/lowampa_trig_qualifier_if.sv | 29 ++
 rtl/lowampa_trig_qualifier.sv | 85 ++++++++
 2 files changed

// File: rtl/lowampa_trig_qualifier_if.sv
// lowampa_trig_qualifier_if: trigger/config/status bundle between trigger source and qualifier
//   master: drives trig_i, enable_i, mask_i, stretch_i, holdoff_i, cfg_update_i, cnt_clear_i
//   slave : drives trig_o, any_o, reject_cnt_o
interface lowampa_trig_qualifier_if #(
  parameter int NBEAMS       = 54,
  parameter int NLEVELS      = 2,
  parameter int STRETCH_BITS = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int CNT_BITS     = 16
);
  logic [NLEVELS*NBEAMS-1:0]   trig_i;
  logic                        enable_i;
  logic [NBEAMS-1:0]           mask_i;
  logic [STRETCH_BITS-1:0]     stretch_i;
  logic [HOLDOFF_BITS-1:0]     holdoff_i;
  logic                        cfg_update_i;
  logic                        cnt_clear_i;
  logic [NLEVELS*NBEAMS-1:0]   trig_o;
  logic [NLEVELS-1:0]          any_o;
  logic [NLEVELS*CNT_BITS-1:0] reject_cnt_o;
  modport master (
    output trig_i, enable_i, mask_i, stretch_i, holdoff_i, cfg_update_i, cnt_clear_i,
    input  trig_o, any_o, reject_cnt_o
  );
  modport slave (
    input  trig_i, enable_i, mask_i, stretch_i, holdoff_i, cfg_update_i, cnt_clear_i,
    output trig_o, any_o, reject_cnt_o
  );
endinterface

// File: rtl/lowampa_trig_qualifier.sv
// lowampa_trig_qualifier: per-beam/per-level trigger masking, stretch, holdoff, level OR and reject counters
//   tclk, tclk_resetn : clock, asynchronous active-low reset
//   bus (slave)       : raw triggers and shadow config in; qualified triggers, level ORs, reject counters out
module lowampa_trig_qualifier #(
  parameter int    NBEAMS       = 54,
  parameter int    NLEVELS      = 2,
  parameter int    STRETCH_BITS = 4,
  parameter int    HOLDOFF_BITS = 8,
  parameter int    CNT_BITS     = 16,
  parameter string ZERO_IS_FAKE = "FALSE"
) (
  input logic                     tclk,
  input logic                     tclk_resetn,
  lowampa_trig_qualifier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STRETCH, HOLDOFF} state_t;
  localparam int NT = NLEVELS * NBEAMS;
  localparam int CW = STRETCH_BITS > HOLDOFF_BITS ? STRETCH_BITS : HOLDOFF_BITS;
  localparam bit FAKE0 = (ZERO_IS_FAKE == "TRUE");
  state_t                  st [NT];
  logic [CW-1:0]           cnt [NT];
  logic [CNT_BITS-1:0]     rcnt [NLEVELS];
  logic [NT-1:0]           trig_q, trig_g, hit;
  logic [NLEVELS-1:0]      rej;
  logic [NBEAMS-1:0]       mask_q, mask_eff;
  logic [STRETCH_BITS-1:0] s_q;
  logic [HOLDOFF_BITS-1:0] h_q;
  // a fake beam 0 is folded into the mask so it never fires nor counts
  assign mask_eff = mask_q | NBEAMS'(FAKE0);
  assign trig_g = trig_q & ~{NLEVELS{NBEAMS'(FAKE0)}};
  assign bus.trig_o = trig_g;
  for (genvar i = 0; i < NT; i++) begin : g_hit
    assign hit[i] = bus.enable_i & bus.trig_i[i] & ~mask_eff[i % NBEAMS] & (st[i] != IDLE);
  end
  for (genvar l = 0; l < NLEVELS; l++) begin : g_lvl
    assign rej[l] = |hit[l*NBEAMS +: NBEAMS];
    assign bus.any_o[l] = |trig_g[l*NBEAMS +: NBEAMS];
    assign bus.reject_cnt_o[l*CNT_BITS +: CNT_BITS] = rcnt[l];
  end
  always_ff @(posedge tclk or negedge tclk_resetn)
    if (!tclk_resetn) begin
      mask_q <= '1;
      s_q    <= '0;
      h_q    <= '0;
      trig_q <= '0;
      for (int i = 0; i < NT; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      for (int l = 0; l < NLEVELS; l++) rcnt[l] <= '0;
    end else begin
      if (bus.cfg_update_i) begin
        mask_q <= bus.mask_i;
        s_q    <= bus.stretch_i;
        h_q    <= bus.holdoff_i;
      end
      for (int l = 0; l < NLEVELS; l++)
        rcnt[l] <= bus.cnt_clear_i ? '0 : rcnt[l] + CNT_BITS'(rej[l] & ~&rcnt[l]);
      for (int i = 0; i < NT; i++) begin
        if (!bus.enable_i || mask_eff[i % NBEAMS]) begin
          st[i]     <= IDLE;
          cnt[i]    <= '0;
          trig_q[i] <= 1'b0;
        end else
          case (st[i])
            IDLE:
              if (bus.trig_i[i]) begin
                st[i]     <= STRETCH;
                cnt[i]    <= CW'(s_q);
                trig_q[i] <= 1'b1;
              end
            STRETCH:
              if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
              else begin
                trig_q[i] <= 1'b0;
                st[i]     <= h_q == '0 ? IDLE : HOLDOFF;
                cnt[i]    <= CW'(h_q) - CW'(1);
              end
            default:
              if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
              else st[i] <= IDLE;
          endcase
      end
    end
endmodule
